// File: rtl/mem_access_stage_if.sv
// Data-memory port bundle between the MEM stage (master) and the data memory (slave).
// The master holds req/we/addr/be/wdata stable until gnt; the slave answers loads with rvalid/rdata.
interface mem_access_stage_if #(
  parameter int NB_DATA = 32
);
  logic               req;
  logic               we;
  logic [NB_DATA-1:0] addr;
  logic [3:0]         be;
  logic [NB_DATA-1:0] wdata;
  logic               gnt;
  logic               rvalid;
  logic [NB_DATA-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/gnt/rvalid memory port, stalls until the
// access completes, then fills the MEM/WB register (bubbles while stalled).
module mem_access_stage #(
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_M_CTRL  = 6,
  parameter int NB_WB_CTRL = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [NB_M_CTRL-1:0]  i_M_control,
  input  logic [NB_WB_CTRL-1:0] i_WB_control,
  input  logic [NB_DATA-1:0]    i_result_alu,
  input  logic [NB_DATA-1:0]    i_data_write_mem,
  input  logic [NB_REG-1:0]     i_write_register,
  output logic                  o_stall,
  mem_access_stage_if.master    io_mem,
  output logic [NB_WB_CTRL-1:0] o_WB_control,
  output logic [NB_DATA-1:0]    o_read_data,
  output logic [NB_DATA-1:0]    o_result_alu,
  output logic [NB_REG-1:0]     o_write_register,
  output logic                  o_misaligned
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GNT   = 2'd1,
    WAIT_RDATA = 2'd2
  } state_t;

  state_t r_state;

  logic                  w_is_store;
  logic                  w_is_load;
  logic                  w_mem_op;
  logic [1:0]            w_size;
  logic [1:0]            w_k;
  logic                  w_misaligned;
  logic                  w_aligned_op;
  logic                  w_req;
  logic                  w_done;
  logic                  w_stall;
  logic [NB_DATA-1:0]    w_load_data;
  logic                  w_unused_ctrl;

  // Size 2'b11 behaves as a word; replication puts the store data on every lane it may target.
  function automatic logic [NB_DATA-1:0] f_store_lanes(input logic [1:0]         size,
                                                       input logic [NB_DATA-1:0] d);
    case (size)
      2'b00:   f_store_lanes = {4{d[7:0]}};
      2'b01:   f_store_lanes = {2{d[15:0]}};
      default: f_store_lanes = d;
    endcase
  endfunction

  function automatic logic [3:0] f_store_be(input logic [1:0] size, input logic [1:0] k);
    case (size)
      2'b00:   f_store_be = 4'b0001 << k;
      2'b01:   f_store_be = 4'b0011 << {k[1], 1'b0};
      default: f_store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [NB_DATA-1:0] f_load_ext(input logic [1:0]         size,
                                                    input logic               uns,
                                                    input logic [1:0]         k,
                                                    input logic [NB_DATA-1:0] rdata);
    logic [NB_DATA-1:0] shifted;
    logic [7:0]         b;
    logic [15:0]        h;
    shifted = rdata >> {k, 3'b000};
    b       = shifted[7:0];
    h       = k[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   f_load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   f_load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: f_load_ext = rdata;
    endcase
  endfunction

  // Store wins when both read and write are set.
  assign w_is_store    = i_M_control[1];
  assign w_is_load     = i_M_control[0] & ~i_M_control[1];
  assign w_mem_op      = i_M_control[0] | i_M_control[1];
  assign w_size        = i_M_control[3:2];
  assign w_k           = i_result_alu[1:0];
  assign w_unused_ctrl = i_M_control[5];

  assign w_misaligned = w_mem_op &
                        (((w_size == 2'b01) & w_k[0]) | (w_size[1] & (w_k != 2'b00)));
  assign w_aligned_op = w_mem_op & ~w_misaligned;

  always_comb begin
    w_done = 1'b0;
    case (r_state)
      IDLE:       w_done = w_aligned_op & w_is_store & io_mem.gnt;
      WAIT_GNT:   w_done = w_is_store & io_mem.gnt;
      WAIT_RDATA: w_done = io_mem.rvalid;
      default:    w_done = 1'b0;
    endcase
  end

  // Reset gates the combinational handshake so an aborted access drops its request at once.
  assign w_req   = i_reset_n & (((r_state == IDLE) & w_aligned_op) | (r_state == WAIT_GNT));
  assign w_stall = i_reset_n & w_aligned_op & ~w_done;
  assign o_stall = w_stall;

  assign io_mem.req   = w_req;
  assign io_mem.we    = w_req & w_is_store;
  assign io_mem.addr  = {i_result_alu[NB_DATA-1:2], 2'b00};
  assign io_mem.be    = w_is_store ? f_store_be(w_size, w_k) : 4'b1111;
  assign io_mem.wdata = f_store_lanes(w_size, i_data_write_mem);

  assign w_load_data = f_load_ext(w_size, i_M_control[4], w_k, io_mem.rdata);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aligned_op) begin
            if (io_mem.gnt) r_state <= w_is_store ? IDLE : WAIT_RDATA;
            else            r_state <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (io_mem.gnt) r_state <= w_is_store ? IDLE : WAIT_RDATA;
        end
        WAIT_RDATA: begin
          if (io_mem.rvalid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the finished instruction.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_WB_control     <= '0;
      o_read_data      <= '0;
      o_result_alu     <= '0;
      o_write_register <= '0;
      o_misaligned     <= 1'b0;
    end else if (w_stall) begin
      o_WB_control     <= '0;
      o_read_data      <= '0;
      o_result_alu     <= '0;
      o_write_register <= '0;
      o_misaligned     <= 1'b0;
    end else begin
      o_WB_control     <= {i_WB_control[NB_WB_CTRL-1:1], i_WB_control[0] & ~w_misaligned};
      o_read_data      <= (w_is_load & ~w_misaligned) ? w_load_data : '0;
      o_result_alu     <= i_result_alu;
      o_write_register <= i_write_register;
      o_misaligned     <= w_misaligned;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-abort sequence and randomized
// transactions checked against a transaction-level model of the stage.
module tb_mem_access_stage;

  typedef struct {
    logic [5:0]  m;
    logic [2:0]  wb;
    logic [31:0] alu;
    logic [31:0] d;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gd;
    int          rdl;
    int          x_stall;
    logic [31:0] x_rdata;
    logic [2:0]  x_wb;
    logic        x_mis;
    logic        x_we;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  M;
  logic [2:0]  WB;
  logic [31:0] alu;
  logic [31:0] dw;
  logic [4:0]  rd;
  logic        stall;
  logic [2:0]  owb;
  logic [31:0] ordata;
  logic [31:0] oalu;
  logic [4:0]  ord;
  logic        omis;
  int          total;
  int          bad;
  bit          spur;
  vec_t        tbl[$];

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_M_control      (M),
    .i_WB_control     (WB),
    .i_result_alu     (alu),
    .i_data_write_mem (dw),
    .i_write_register (rd),
    .o_stall          (stall),
    .io_mem           (bus),
    .o_WB_control     (owb),
    .o_read_data      (ordata),
    .o_result_alu     (oalu),
    .o_write_register (ord),
    .o_misaligned     (omis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: what the stage must do with one EX/MEM instruction.
  function automatic vec_t model(input logic [5:0] m, input logic [2:0] wb,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [4:0] r, input logic [31:0] rdata,
                                 input int gd, input int rdl);
    vec_t        v;
    int          nb, k, lo;
    logic [31:0] mask, val;
    logic        st, ld, mem, mis;
    v.m = m; v.wb = wb; v.alu = a; v.d = d; v.rd = r; v.rdata = rdata; v.gd = gd; v.rdl = rdl;
    st  = m[1];
    ld  = m[0] && !m[1];
    mem = st || ld;
    nb  = (m[3:2] == 2'd0) ? 1 : (m[3:2] == 2'd1) ? 2 : 4;
    k   = int'(a[1:0]);
    lo  = k - (k % nb);
    mis = mem && ((k % nb) != 0);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    val  = (rdata >> (8 * lo)) & mask;
    if (!m[4] && nb < 4 && val[8*nb-1]) val = val | ~mask;
    v.x_mis   = mis;
    v.x_stall = (!mem || mis) ? 0 : (st ? gd : gd + rdl);
    v.x_rdata = (ld && !mis) ? val : 32'h0;
    v.x_wb    = {wb[2:1], wb[0] & !mis};
    v.x_we    = st;
    v.x_be    = ld ? 4'hF : 4'(((1 << nb) - 1) << lo);
    v.x_wdata = (nb == 4) ? d : (nb == 2) ? d[15:0] * 32'h0001_0001 : d[7:0] * 32'h0101_0101;
    return v;
  endfunction

  function automatic vec_t mkv(input logic [5:0] m, input logic [2:0] wb, input logic [31:0] a,
                               input logic [31:0] d, input logic [4:0] r, input logic [31:0] rdata,
                               input int gd, input int rdl, input int xs, input logic [31:0] xr,
                               input logic [2:0] xwb, input logic xmis, input logic xwe,
                               input logic [3:0] xbe, input logic [31:0] xwd);
    vec_t v;
    v.m = m; v.wb = wb; v.alu = a; v.d = d; v.rd = r; v.rdata = rdata; v.gd = gd; v.rdl = rdl;
    v.x_stall = xs; v.x_rdata = xr; v.x_wb = xwb; v.x_mis = xmis;
    v.x_we = xwe; v.x_be = xbe; v.x_wdata = xwd;
    return v;
  endfunction

  // Plays one instruction: memory answers with gnt after gd request cycles, rvalid rdl cycles later.
  task automatic do_op(input vec_t v);
    logic        is_load, aligned_mem, granted, want_req;
    logic [31:0] xaddr;
    granted     = 1'b0;
    is_load     = v.m[0] & ~v.m[1];
    aligned_mem = (v.m[0] | v.m[1]) & ~v.x_mis;
    xaddr       = {v.alu[31:2], 2'b00};
    for (int cyc = 0; cyc <= v.x_stall; cyc++) begin
      @(negedge clk);
      bus.gnt = 1'b0; bus.rvalid = 1'b0;
      M = v.m; WB = v.wb; alu = v.alu; dw = v.d; rd = v.rd;
      #1;
      want_req = aligned_mem && !granted;
      chk("req", 128'(bus.req), 128'(want_req));
      if (want_req)
        chk("bus", {bus.we, bus.addr, bus.be, bus.wdata}, {v.x_we, xaddr, v.x_be, v.x_wdata});
      if (want_req && cyc == v.gd) bus.gnt = 1'b1;
      if (is_load && granted && cyc == v.gd + v.rdl) begin
        bus.rvalid = 1'b1; bus.rdata = v.rdata;
      end else if (!granted && spur && ($urandom_range(1, 0) == 1)) begin
        bus.rvalid = 1'b1; bus.rdata = $urandom;
      end
      #1;
      chk("stall", 128'(stall), 128'(cyc < v.x_stall));
      @(posedge clk);
      #1;
      if (cyc < v.x_stall)
        chk("bubble", {owb, ord, oalu, ordata, omis}, 128'h0);
      else
        chk("memwb", {owb, ord, oalu, ordata, omis}, {v.x_wb, v.rd, v.alu, v.x_rdata, v.x_mis});
      if (bus.gnt) granted = 1'b1;
    end
  endtask

  initial begin
    total = 0; bad = 0; spur = 1'b0;
    rst_n = 1'b0;
    M = '0; WB = '0; alu = '0; dw = '0; rd = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    #3;
    chk("rst_out", {owb, ord, oalu, ordata, omis, stall, bus.req}, 128'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    //          m         wb     alu           d             rd  rdata         gd rdl xs xrdata        xwb    mis we  be       wdata
    tbl.push_back(mkv(6'b000000, 3'b001, 32'h1234, 32'h0, 5'd7, 32'h0, 0, 1, 0, 32'h0, 3'b001, 0, 0, 4'hF, 32'h0));
    tbl.push_back(mkv(6'b000001, 3'b001, 32'h103, 32'h0, 5'd5, 32'h80FF_FF00, 0, 3, 3, 32'hFFFF_FF80, 3'b001, 0, 0, 4'hF, 32'h0));
    tbl.push_back(mkv(6'b000110, 3'b000, 32'h102, 32'hABCD, 5'd0, 32'h0, 2, 1, 2, 32'h0, 3'b000, 0, 1, 4'b1100, 32'hABCD_ABCD));
    tbl.push_back(mkv(6'b001001, 3'b001, 32'h101, 32'h0, 5'd9, 32'h0, 0, 1, 0, 32'h0, 3'b000, 1, 0, 4'hF, 32'h0));
    tbl.push_back(mkv(6'b010101, 3'b001, 32'h2, 32'h0, 5'd3, 32'h8001_0000, 1, 1, 2, 32'h0000_8001, 3'b001, 0, 0, 4'hF, 32'h0));
    tbl.push_back(mkv(6'b000101, 3'b001, 32'h2, 32'h0, 5'd3, 32'h8001_0000, 0, 2, 2, 32'hFFFF_8001, 3'b001, 0, 0, 4'hF, 32'h0));
    tbl.push_back(mkv(6'b000010, 3'b000, 32'h3, 32'h1234_5678, 5'd0, 32'h0, 0, 1, 0, 32'h0, 3'b000, 0, 1, 4'b1000, 32'h7878_7878));
    tbl.push_back(mkv(6'b001011, 3'b000, 32'h10, 32'hDEAD_BEEF, 5'd0, 32'h0, 1, 1, 1, 32'h0, 3'b000, 0, 1, 4'hF, 32'hDEAD_BEEF));
    tbl.push_back(mkv(6'b000110, 3'b101, 32'h21, 32'h5555, 5'd4, 32'h0, 0, 1, 0, 32'h0, 3'b100, 1, 1, 4'hF, 32'h0));
    foreach (tbl[i]) do_op(tbl[i]);

    // Reset while waiting for load data: request and stall drop, late rvalid is ignored.
    @(negedge clk);
    M = 6'b001001; WB = 3'b001; alu = 32'h200; dw = '0; rd = 5'd12;
    bus.gnt = 1'b1; bus.rvalid = 1'b0;
    #1;
    chk("r6_req", 128'(bus.req), 128'h1);
    @(posedge clk); #1;
    chk("r6_wait", 128'(stall), 128'h1);
    @(negedge clk);
    bus.gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("r6_rst", {owb, ord, oalu, ordata, omis, stall, bus.req}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    M = '0; WB = '0; alu = '0; rd = '0;
    bus.rvalid = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    #1;
    chk("r6_idle", {stall, bus.req}, 128'h0);
    @(posedge clk); #1;
    chk("r6_memwb", {owb, ord, oalu, ordata, omis}, 128'h0);
    do_op(tbl[1]);

    spur = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [5:0]  m;
      logic [31:0] a;
      m = 6'($urandom);
      if ($urandom_range(3, 0) == 0) m[1:0] = 2'b00;
      a = {$urandom_range(255, 0) << 4} | 32'($urandom_range(3, 0));
      do_op(model(m, 3'($urandom), a, $urandom, 5'($urandom), $urandom,
                  $urandom_range(3, 0), $urandom_range(3, 1)));
    end

    @(negedge clk);
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
